// File: rtl/conc_trace_recorder.sv
// rtl/conc_trace_recorder.sv - packs live stimulus into opcodes with the DUT response, then replays the trace in address order
module conc_trace_recorder #(
    parameter int DEPTH = 101,
    parameter int AW    = 7,
    parameter int X_W   = 6
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           arm,
    input  logic           stop,
    input  logic           obs,
    input  logic           stbi,
    input  logic [X_W-1:0] x_in,
    input  logic [X_W-1:0] x_out,
    input  logic           rd_ready,
    output logic           rd_valid,
    output logic [AW-1:0]  rd_addr,
    output logic [7:0]     rd_opcode,
    output logic [X_W-1:0] rd_resp,
    output logic           busy,
    output logic           done,
    output logic [AW-1:0]  count,
    output logic           overflow
);
    localparam int EW = 8 + X_W;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ONE = AW'(1);

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;

    state_t        state;
    logic [EW-1:0] trace_mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] fetch_ptr;
    logic          wr_en;
    logic          fetch_en;

    assign wr_en = !reset && (state == CAPTURE);

    // The output register doubles as the skid stage: refill it whenever it is empty or being drained.
    assign fetch_en = (state == DRAIN) && (!rd_valid || rd_ready) && (fetch_ptr <= count);

    always_ff @(posedge clock) begin
        if (wr_en) begin
            trace_mem[wp] <= {obs, stbi, x_in, x_out};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            wp        <= ONE;
            fetch_ptr <= ONE;
            count     <= '0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_valid  <= 1'b0;
            rd_addr   <= '0;
            rd_opcode <= '0;
            rd_resp   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (arm) begin
                        state    <= CAPTURE;
                        wp       <= ONE;
                        count    <= '0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                CAPTURE: begin
                    wp    <= wp + ONE;
                    count <= count + ONE;
                    if (stop || (wp == LAST_ADDR)) begin
                        state     <= DRAIN;
                        overflow  <= (wp == LAST_ADDR) && !stop;
                        fetch_ptr <= ONE;
                        rd_valid  <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (fetch_en) begin
                        rd_valid               <= 1'b1;
                        rd_addr                <= fetch_ptr;
                        {rd_opcode, rd_resp}   <= trace_mem[fetch_ptr];
                        fetch_ptr              <= fetch_ptr + ONE;
                    end else if (rd_valid && rd_ready) begin
                        rd_valid <= 1'b0;
                        if (rd_addr == count) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
